// File: rtl/spi_pkg.sv
// Shared frame layout, FSM encoding and frame packing for the 32-bit SPI register-access controller.
package spi_pkg;

    localparam int FRAME_BITS = 32;
    localparam int ADDR_BITS  = 8;
    localparam int DATA_BITS  = 16;
    localparam int TURN_BITS  = 7;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    // Reads send zeros in the data field so the peripheral can drive MISO there.
    function automatic logic [FRAME_BITS-1:0] pack_frame(
        input logic                 rw,
        input logic [ADDR_BITS-1:0] addr,
        input logic [DATA_BITS-1:0] wdata
    );
        return {rw, addr, {TURN_BITS{1'b0}}, (rw == RW_WRITE) ? wdata : {DATA_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/spi_controller_if.sv
// Request/response handshake between a host sequencer and spi_controller.
interface spi_controller_if;
    import spi_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_rw;
    logic [ADDR_BITS-1:0] req_addr;
    logic [DATA_BITS-1:0] req_wdata;
    logic                 rsp_valid;
    logic [DATA_BITS-1:0] rsp_rdata;
    logic                 busy;

    modport master (
        output req_valid, req_rw, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, busy
    );

endinterface

// File: rtl/spi_clk_gen.sv
// SCLK divider: toggles every CLK_DIV clks while enabled, held low otherwise; emits rise/fall strobes.
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_sclk,
    output logic o_rise,
    output logic o_fall
);

    logic [7:0] r_divCnt;
    logic       r_sclk;
    logic       w_tick;

    assign w_tick = i_en && (r_divCnt == 8'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_divCnt <= 8'd0;
            r_sclk   <= 1'b0;
        end else if (!i_en) begin
            r_divCnt <= 8'd0;
            r_sclk   <= 1'b0;
        end else if (w_tick) begin
            r_divCnt <= 8'd0;
            r_sclk   <= ~r_sclk;
        end else begin
            r_divCnt <= r_divCnt + 8'd1;
        end
    end

    // Strobes mark the clk edge on which the registered SCLK changes.
    assign o_sclk = r_sclk;
    assign o_rise = w_tick & ~r_sclk;
    assign o_fall = w_tick &  r_sclk;

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 initiator for 32-bit register frames: IDLE -> SETUP -> SHIFT -> HOLD -> GAP.
// Optional SPI_CTRL_BUSY_ERR_EN adds a sticky busy_err flag with busy_err_clr.
module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV      = 4,
    parameter int CS_SETUP_CYC = 2,
    parameter int CS_HOLD_CYC  = 2,
    parameter int GAP_CYC      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_controller_if.slave  bus,
`ifdef SPI_CTRL_BUSY_ERR_EN
    output logic             busy_err,
    input  logic             busy_err_clr,
`endif
    output logic             SCLK,
    output logic             CSN,
    output logic             MOSI,
    input  logic             MISO
);

    state_t                  r_state, w_nextState;
    logic [7:0]              r_cnt;
    logic [4:0]              r_bit;
    logic [FRAME_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]    r_rdataSr, r_rspRdata;
    logic                    r_rw, r_csn, r_mosi, r_reqReady, r_rspValid, r_busy;
    logic                    w_accept, w_cntDone, w_sclkRise, w_sclkFall;
    logic [FRAME_BITS-1:0]   w_frame;

    assign w_frame  = pack_frame(bus.req_rw, bus.req_addr, bus.req_wdata);
    assign w_accept = bus.req_valid && r_reqReady && (r_state == ST_IDLE);

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (r_state == ST_SHIFT),
        .o_sclk (SCLK),
        .o_rise (w_sclkRise),
        .o_fall (w_sclkFall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        w_cntDone   = 1'b0;
        case (r_state)
            ST_IDLE:  if (w_accept) w_nextState = ST_SETUP;
            ST_SETUP: begin
                w_cntDone = (r_cnt == 8'(CS_SETUP_CYC - 1));
                if (w_cntDone) w_nextState = ST_SHIFT;
            end
            ST_SHIFT: if (w_sclkFall && (r_bit == 5'd0)) w_nextState = ST_HOLD;
            ST_HOLD: begin
                w_cntDone = (r_cnt == 8'(CS_HOLD_CYC - 1));
                if (w_cntDone) w_nextState = ST_GAP;
            end
            ST_GAP: begin
                w_cntDone = (r_cnt == 8'(GAP_CYC - 1));
                if (w_cntDone) w_nextState = ST_IDLE;
            end
            default:  w_nextState = ST_IDLE;
        endcase
    end

    // Phase counter restarts on every state change; MOSI moves only on SCLK falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= 8'd0;
            r_bit      <= 5'd0;
            r_shift    <= '0;
            r_rdataSr  <= '0;
            r_rspRdata <= '0;
            r_rw       <= 1'b0;
            r_csn      <= 1'b1;
            r_mosi     <= 1'b0;
            r_reqReady <= 1'b0;
            r_rspValid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_reqReady <= (w_nextState == ST_IDLE);
            r_busy     <= (w_nextState != ST_IDLE);
            r_rspValid <= 1'b0;
            r_cnt      <= (w_nextState != r_state) ? 8'd0 : r_cnt + 8'd1;
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_shift   <= w_frame;
                    r_rw      <= bus.req_rw;
                    r_mosi    <= w_frame[FRAME_BITS-1];
                    r_csn     <= 1'b0;
                    r_bit     <= 5'(FRAME_BITS - 1);
                    r_rdataSr <= '0;
                end
                ST_SHIFT: begin
                    if (w_sclkRise && (r_bit < 5'(DATA_BITS)))
                        r_rdataSr <= {r_rdataSr[DATA_BITS-2:0], MISO};
                    if (w_sclkFall) begin
                        if (r_bit == 5'd0) begin
                            r_mosi <= 1'b0;
                        end else begin
                            r_bit   <= r_bit - 5'd1;
                            r_shift <= r_shift << 1;
                            r_mosi  <= r_shift[FRAME_BITS-2];
                        end
                    end
                end
                ST_HOLD: if (w_cntDone) begin
                    r_csn      <= 1'b1;
                    r_rspValid <= 1'b1;
                    if (r_rw != RW_WRITE) r_rspRdata <= r_rdataSr;
                end
                default: ;
            endcase
        end
    end

`ifdef SPI_CTRL_BUSY_ERR_EN
    logic r_busyErr;
    logic w_busyErrSet;

    assign w_busyErrSet = bus.req_valid && (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_busyErr <= 1'b0;
        else        r_busyErr <= w_busyErrSet | (r_busyErr & ~busy_err_clr);
    end

    assign busy_err = r_busyErr;
`endif

    assign CSN           = r_csn;
    assign MOSI          = r_mosi;
    assign bus.req_ready = r_reqReady;
    assign bus.rsp_valid = r_rspValid;
    assign bus.rsp_rdata = r_rspRdata;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller with a mode-0 peripheral model capturing MOSI and driving MISO.
module tb_spi_controller;

    localparam int CLK_PER = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic SCLK, CSN, MOSI, MISO;
`ifdef SPI_CTRL_BUSY_ERR_EN
    logic busyErr;
    logic busyErrClr = 1'b0;
`endif

    spi_controller_if bus();

    spi_controller #(
        .CLK_DIV(2), .CS_SETUP_CYC(2), .CS_HOLD_CYC(2), .GAP_CYC(4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
`ifdef SPI_CTRL_BUSY_ERR_EN
        .busy_err     (busyErr),
        .busy_err_clr (busyErrClr),
`endif
        .SCLK         (SCLK),
        .CSN          (CSN),
        .MOSI         (MOSI),
        .MISO         (MISO)
    );

    always #(CLK_PER/2) clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;
    int rspCnt     = 0;
    int riseCnt    = 0;
    int sclkBad    = 0;
    int readyBad   = 0;
    logic [15:0] periphData = 16'h0;
    logic [15:0] lastRdata  = 16'h0;
    logic [31:0] mosiCap    = 32'h0;
    logic [31:0] misoSr     = 32'h0;
    logic [31:0] mosiLog[$];
    int          riseLog[$];
    longint fallTime = 0, riseTime = 0, lowCycles = 0, gapLast = 0;

    // Peripheral model: shifts MISO out after each SCLK fall, captures MOSI on each rise.
    assign MISO = misoSr[31];

    always @(negedge CSN) begin
        misoSr   <= {16'h0, periphData};
        mosiCap  <= 32'h0;
        riseCnt  <= 0;
        fallTime <= $time;
        gapLast  <= ($time - riseTime) / CLK_PER;
    end

    always @(posedge CSN) begin
        mosiLog.push_back(mosiCap);
        riseLog.push_back(riseCnt);
        lowCycles <= ($time - fallTime) / CLK_PER;
        riseTime  <= $time;
    end

    always @(posedge SCLK) begin
        if (CSN) sclkBad <= sclkBad + 1;
        mosiCap <= {mosiCap[30:0], MOSI};
        riseCnt <= riseCnt + 1;
    end

    always @(negedge SCLK) misoSr <= misoSr << 1;

    always @(posedge clk) begin
        if (bus.rsp_valid === 1'b1) begin
            rspCnt    <= rspCnt + 1;
            lastRdata <= bus.rsp_rdata;
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus.req_ready && (bus.busy || !CSN)) readyBad <= readyBad + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        else passCount++;
    endtask

    // Presents a request and waits (bounded) for the handshake; leaves req_valid as set.
    task automatic applyStimulus(input logic rw, input logic [7:0] addr, input logic [15:0] wdata);
        bit accepted = 1'b0;
        @(negedge clk);
        bus.req_rw    = rw;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 400 && !accepted; i++) begin
            @(posedge clk);
            if (bus.req_ready === 1'b1) accepted = 1'b1;
        end
        @(negedge clk);
        if (!accepted) checkOutput("accept_timeout", 32'(accepted), 32'd1);
    endtask

    task automatic waitRsp(input int target);
        for (int i = 0; i < 600 && rspCnt < target; i++) @(negedge clk);
        checkOutput("rsp_count", 32'(rspCnt), 32'(target));
    endtask

    task automatic waitRises(input int target);
        for (int i = 0; i < 400 && riseCnt < target; i++) @(negedge clk);
        checkOutput("rise_reach", 32'(riseCnt >= target), 32'd1);
    endtask

    initial begin
        int base;
        bus.req_valid = 1'b0;
        bus.req_rw    = 1'b0;
        bus.req_addr  = 8'h0;
        bus.req_wdata = 16'h0;

        // Reset state
        @(negedge clk);
        checkOutput("rst_csn",       32'(CSN), 32'd1);
        checkOutput("rst_sclk",      32'(SCLK), 32'd0);
        checkOutput("rst_mosi",      32'(MOSI), 32'd0);
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("rst_busy",      32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_rst", 32'(bus.req_ready), 32'd1);

        // Write 0x12 <- 0xBEEF; rsp_rdata must stay at its reset value
        periphData = 16'h1234;
        base = rspCnt;
        applyStimulus(1'b1, 8'h12, 16'hBEEF);
        bus.req_valid = 1'b0;
        checkOutput("wr_csn_low",  32'(CSN), 32'd0);
        checkOutput("wr_busy",     32'(bus.busy), 32'd1);
        checkOutput("wr_mosi_msb", 32'(MOSI), 32'd1);
        waitRsp(base + 1);
        checkOutput("wr_mosi_frame", mosiLog[$], 32'h8900BEEF);
        checkOutput("wr_rises",      32'(riseLog[$]), 32'd32);
        checkOutput("wr_csn_cycles", 32'(lowCycles), 32'd132);
        checkOutput("wr_rdata_keep", 32'(bus.rsp_rdata), 32'h0);

        // Read 0x05, peripheral returns 0xA5C3
        periphData = 16'hA5C3;
        base = rspCnt;
        applyStimulus(1'b0, 8'h05, 16'hFFFF);
        bus.req_valid = 1'b0;
        waitRsp(base + 1);
        checkOutput("rd_mosi_frame", mosiLog[$], 32'h02800000);
        checkOutput("rd_rdata",      32'(lastRdata), 32'h0000A5C3);
        checkOutput("rd_rises",      32'(riseLog[$]), 32'd32);

        // Back-to-back: req_valid held across write then read
        periphData = 16'h0F0F;
        base = rspCnt;
        applyStimulus(1'b1, 8'h34, 16'h1357);
        applyStimulus(1'b0, 8'h56, 16'h0000);
        bus.req_valid = 1'b0;
        waitRsp(base + 2);
        checkOutput("b2b_wr_frame", mosiLog[$-1], 32'h9A001357);
        checkOutput("b2b_rd_frame", mosiLog[$], 32'h2B000000);
        checkOutput("b2b_gap_min",  32'(gapLast >= 4), 32'd1);
        checkOutput("b2b_rdata",    32'(lastRdata), 32'h00000F0F);
        checkOutput("b2b_ready_idle_only", 32'(readyBad), 32'd0);

        // Reset mid-frame aborts without a response
        base = rspCnt;
        applyStimulus(1'b1, 8'hC3, 16'hFFFF);
        bus.req_valid = 1'b0;
        waitRises(11);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_csn",  32'(CSN), 32'd1);
        checkOutput("abort_sclk", 32'(SCLK), 32'd0);
        checkOutput("abort_mosi", 32'(MOSI), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("abort_no_rsp", 32'(rspCnt), 32'(base));
        checkOutput("abort_rdata_clr", 32'(bus.rsp_rdata), 32'h0);
        rst_n = 1'b1;
        applyStimulus(1'b1, 8'h7E, 16'h0001);
        bus.req_valid = 1'b0;
        waitRsp(base + 1);
        checkOutput("post_abort_frame", mosiLog[$], 32'hBF000001);
        checkOutput("post_abort_rises", 32'(riseLog[$]), 32'd32);
        checkOutput("post_abort_csn",   32'(lowCycles), 32'd132);

        // req_valid pulsed during SHIFT must not disturb the frame
`ifdef SPI_CTRL_BUSY_ERR_EN
        busyErrClr = 1'b1;
        @(negedge clk);
        busyErrClr = 1'b0;
        checkOutput("berr_cleared_start", 32'(busyErr), 32'd0);
`endif
        base = rspCnt;
        applyStimulus(1'b0, 8'h33, 16'h0000);
        bus.req_valid = 1'b0;
        waitRises(5);
        bus.req_valid = 1'b1;
        bus.req_rw    = 1'b1;
        bus.req_addr  = 8'hFF;
        bus.req_wdata = 16'hFFFF;
        repeat (3) @(negedge clk);
        bus.req_valid = 1'b0;
        waitRsp(base + 1);
        checkOutput("busy_req_frame", mosiLog[$], 32'h19800000);
        checkOutput("busy_req_rises", 32'(riseLog[$]), 32'd32);
        repeat (12) @(negedge clk);
        checkOutput("busy_req_single", 32'(rspCnt), 32'(base + 1));
        checkOutput("busy_req_csn_idle", 32'(CSN), 32'd1);
`ifdef SPI_CTRL_BUSY_ERR_EN
        checkOutput("berr_set", 32'(busyErr), 32'd1);
        busyErrClr = 1'b1;
        @(negedge clk);
        busyErrClr = 1'b0;
        @(negedge clk);
        checkOutput("berr_clr", 32'(busyErr), 32'd0);
`endif
        checkOutput("sclk_only_csn_low", 32'(sclkBad), 32'd0);
        checkOutput("ready_idle_only",   32'(readyBad), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
